// File: rtl/text_pkg.sv
// Shared constants and types for the text overlay / font ROM datapath.
package text_pkg;

   localparam int unsigned FONT_ADDR_W = 11;
   localparam int unsigned FONT_DATA_W = 8;
   localparam int unsigned GLYPH_COL_W = 3;
   localparam int unsigned SRC_IDX_W   = 2;

   typedef logic [FONT_ADDR_W-1:0] font_addr_t;
   typedef logic [FONT_DATA_W-1:0] font_data_t;
   typedef logic [GLYPH_COL_W-1:0] glyph_col_t;
   typedef logic [SRC_IDX_W-1:0]   src_idx_t;

   // Fixed source slots; lower index wins the ROM.
   localparam src_idx_t SRC_START    = 2'd0;
   localparam src_idx_t SRC_SCORE    = 2'd1;
   localparam src_idx_t SRC_GAMEOVER = 2'd2;
   localparam src_idx_t SRC_PAUSE    = 2'd3;

endpackage

// File: rtl/blink_timer.sv
// Counts frame ticks and toggles blink_phase every BLINK_FRAMES ticks.
module blink_timer #(
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic clk,
   input  logic rst_n,
   input  logic frame_tick,
   output logic blink_phase
);

   localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

   generate
      if (BLINK_FRAMES < 1) begin : g_bad_frames
         $error("blink_timer: BLINK_FRAMES must be at least 1");
      end
   endgenerate

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;

   // Advance only on frame_tick; wrap and flip the phase at the half-period end.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (frame_tick) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Counter and phase state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign blink_phase = phase_q;

endmodule

// File: rtl/text_rom_arbiter.sv
// Fixed-priority arbiter sharing one synchronous font ROM among text overlays,
// followed by a two-stage pixel pipeline (address issue, then glyph bit select).
module text_rom_arbiter
   import text_pkg::*;
#(
   parameter int unsigned NUM_SRC      = 4,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_SRC-1:0]                 src_on,
   input  logic [FONT_ADDR_W*NUM_SRC-1:0]     src_rom_addr,
   input  logic [GLYPH_COL_W*NUM_SRC-1:0]     src_bit_addr,
   input  logic [NUM_SRC-1:0]                 blink_mask,
   input  logic                               video_on,
   input  logic                               frame_tick,
   output logic [FONT_ADDR_W-1:0]             font_rom_addr,
   input  logic [FONT_DATA_W-1:0]             font_rom_data,
   output logic                               text_on,
   output logic [SRC_IDX_W-1:0]               text_src
);

   // text_src is only 2 bits wide, so at most four sources are addressable.
   generate
      if (NUM_SRC < 1 || NUM_SRC > 4) begin : g_bad_num_src
         $error("text_rom_arbiter: NUM_SRC must be in 1..4");
      end
   endgenerate

   logic blink_phase;

   blink_timer #(
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_blink_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_tick  (frame_tick),
      .blink_phase (blink_phase)
   );

   logic       grant_valid;
   src_idx_t   grant_idx;
   font_addr_t grant_addr;
   glyph_col_t grant_col;

   // Stage 0: lowest-index source that is on and not blanked by blink wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      grant_addr  = '0;
      grant_col   = '0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         if (!grant_valid && src_on[i] && !(blink_mask[i] && blink_phase)) begin
            grant_valid = 1'b1;
            grant_idx   = SRC_IDX_W'(i);
            grant_addr  = src_rom_addr[i*FONT_ADDR_W +: FONT_ADDR_W];
            grant_col   = src_bit_addr[i*GLYPH_COL_W +: GLYPH_COL_W];
         end
      end
   end

   font_addr_t addr_q;
   glyph_col_t col_q;
   src_idx_t   src_q;
   logic       hit_q;

   // Stage 1: issue ROM address; carry column, source and hit alongside.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         col_q  <= '0;
         src_q  <= '0;
         hit_q  <= 1'b0;
      end else begin
         addr_q <= grant_addr;
         col_q  <= grant_col;
         src_q  <= grant_idx;
         hit_q  <= grant_valid && video_on;
      end
   end

   assign font_rom_addr = addr_q;

   logic     text_on_q;
   src_idx_t text_src_q;

   // Stage 2: pick the glyph bit; column 0 is the MSB, so index is ~col (7 - col).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         text_on_q  <= 1'b0;
         text_src_q <= '0;
      end else begin
         text_on_q  <= hit_q && font_rom_data[~col_q];
         text_src_q <= hit_q ? src_q : '0;
      end
   end

   assign text_on  = text_on_q;
   assign text_src = text_src_q;

endmodule

// File: tb/tb_text_rom_arbiter.sv
// Self-checking bench: behavioural reference model plus directed literal checks.
module tb_text_rom_arbiter;

   localparam int NSRC = 4;
   localparam int BF   = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [NSRC-1:0]   src_on = '0;
   logic [11*NSRC-1:0] src_rom_addr = '0;
   logic [3*NSRC-1:0] src_bit_addr = '0;
   logic [NSRC-1:0]   blink_mask = '0;
   logic              video_on = 1'b0;
   logic              frame_tick = 1'b0;
   logic [10:0]       font_rom_addr;
   logic [7:0]        font_rom_data;
   logic              text_on;
   logic [1:0]        text_src;

   int passed = 0;
   int total  = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   // Font ROM contents: 0x528 holds 0x20, everything else a simple hash.
   function automatic logic [7:0] rom(input logic [10:0] a);
      if (a == 11'h528) return 8'h20;
      return a[7:0] ^ 8'hA5;
   endfunction

   assign font_rom_data = rom(font_rom_addr);

   text_rom_arbiter #(
      .NUM_SRC      (NSRC),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .src_on        (src_on),
      .src_rom_addr  (src_rom_addr),
      .src_bit_addr  (src_bit_addr),
      .blink_mask    (blink_mask),
      .video_on      (video_on),
      .frame_tick    (frame_tick),
      .font_rom_addr (font_rom_addr),
      .font_rom_data (font_rom_data),
      .text_on       (text_on),
      .text_src      (text_src)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: per accepted pixel, the full result computed at sample time.
   // Index 0 = most recent sample (seen on font_rom_addr), index 1 = one older (text_on).
   logic [10:0] m_addr [2];
   logic        m_on   [2];
   logic [1:0]  m_src  [2];
   int          ticks;

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_addr[k] = '0; m_on[k] = 1'b0; m_src[k] = '0;
      end
      ticks = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
               m_addr[k] = '0; m_on[k] = 1'b0; m_src[k] = '0;
            end
            ticks = 0;
         end else begin
            bit         phase;
            bit         found;
            int         g;
            logic [10:0] a;
            logic [2:0]  col;
            logic [7:0]  w;
            phase = ((ticks / BF) % 2) == 1;
            found = 1'b0;
            g     = 0;
            for (int i = NSRC - 1; i >= 0; i--) begin
               if (src_on[i] && !(blink_mask[i] && phase)) begin
                  found = 1'b1;
                  g     = i;
               end
            end
            a   = found ? src_rom_addr[g*11 +: 11] : 11'h0;
            col = src_bit_addr[g*3 +: 3];
            w   = rom(a);
            m_addr[1] = m_addr[0];
            m_on[1]   = m_on[0];
            m_src[1]  = m_src[0];
            m_addr[0] = a;
            m_on[0]   = found && video_on && w[7 - int'(col)];
            m_src[0]  = (found && video_on) ? 2'(g) : 2'd0;
            if (frame_tick) ticks++;
         end
      end
   end

   // Compare DUT against model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_addr", 32'(font_rom_addr), 32'(m_addr[0]));
         chk("model_text_on", 32'(text_on), 32'(m_on[1]));
         chk("model_text_src", 32'(text_src), 32'(m_src[1]));
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_src(input int i, input logic [10:0] a, input logic [2:0] b);
      src_rom_addr[i*11 +: 11] = a;
      src_bit_addr[i*3 +: 3]   = b;
   endtask

   task automatic tick_frame();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      step(3);
      chk("reset_addr", 32'(font_rom_addr), 32'h0);
      chk("reset_text_on", 32'(text_on), 32'h0);
      chk("reset_text_src", 32'(text_src), 32'h0);
      #2 rst_n = 1'b1;
      step();

      // Single source.
      set_src(0, 11'h528, 3'd2);
      src_on   = 4'b0001;
      video_on = 1'b1;
      step();
      chk("single_addr", 32'(font_rom_addr), 32'h528);
      step();
      chk("single_text_on", 32'(text_on), 32'h1);
      chk("single_text_src", 32'(text_src), 32'h0);

      // Contention between sources 1 and 2.
      set_src(1, 11'h550, 3'd0);
      set_src(2, 11'h4E0, 3'd1);
      src_on = 4'b0110;
      step();
      chk("contend_addr1", 32'(font_rom_addr), 32'h550);
      step();
      chk("contend_src1", 32'(text_src), 32'h1);
      src_on = 4'b0100;
      step();
      chk("contend_addr2", 32'(font_rom_addr), 32'h4E0);
      step();
      chk("contend_src2", 32'(text_src), 32'h2);

      // Blanking: address still tracks, no hit.
      src_on   = 4'b0001;
      video_on = 1'b0;
      step();
      chk("blank_addr", 32'(font_rom_addr), 32'h528);
      step();
      chk("blank_text_on", 32'(text_on), 32'h0);
      video_on = 1'b1;

      // Blink: two ticks enter the hidden phase.
      blink_mask = 4'b0001;
      tick_frame();
      tick_frame();
      step(3);
      chk("blink_off_text_on", 32'(text_on), 32'h0);
      chk("blink_off_addr", 32'(font_rom_addr), 32'h0);

      // Fallthrough to source 1 while source 0 is hidden.
      src_on = 4'b0011;
      step();
      chk("fall_addr", 32'(font_rom_addr), 32'h550);
      step();
      chk("fall_text_src", 32'(text_src), 32'h1);

      // Two more ticks: visible again.
      src_on = 4'b0001;
      tick_frame();
      tick_frame();
      step(3);
      chk("blink_on_text_on", 32'(text_on), 32'h1);
      blink_mask = 4'b0000;

      // Reset mid-stream during continuous hits.
      step(2);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_addr", 32'(font_rom_addr), 32'h0);
      chk("midrst_text_on", 32'(text_on), 32'h0);
      chk("midrst_text_src", 32'(text_src), 32'h0);
      step();
      #2 rst_n = 1'b1;
      step();
      chk("post_rst_addr", 32'(font_rom_addr), 32'h528);
      chk("post_rst_text_on_p1", 32'(text_on), 32'h0);
      step();
      chk("post_rst_text_on_p2", 32'(text_on), 32'h1);

      // Mixed vectors exercised against the model only.
      for (int n = 0; n < 300; n++) begin
         src_on       = 4'($urandom);
         blink_mask   = 4'($urandom);
         video_on     = ($urandom_range(0, 7) != 0);
         frame_tick   = ($urandom_range(0, 3) == 0);
         src_rom_addr = {12'($urandom), 32'($urandom)};
         src_bit_addr = 12'($urandom);
         step();
      end
      frame_tick = 1'b0;
      step(2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/text_rom_arbiter.md
TEXT_ROM_ARBITER -- requirements
Module: text_rom_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4: number of text-overlay requesters sharing the font ROM.
REQ-002 Parameter BLINK_FRAMES, default 30: frame_tick pulses per blink half-period.
REQ-003 clk  input  1  pixel clock; the block's only clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 src_on  input  NUM_SRC  per-source "pixel inside my text box" flag; bit i belongs to source i.
REQ-006 src_rom_addr  input  11*NUM_SRC  per-source font ROM address {char[6:0], row[3:0]}; source i occupies bits [11i+10:11i].
REQ-007 src_bit_addr  input  3*NUM_SRC  per-source column within the glyph (0 = leftmost).
REQ-008 blink_mask  input  NUM_SRC  bit set = that source blinks.
REQ-009 video_on  input  1  active-display flag, aligned with src_* inputs.
REQ-010 frame_tick  input  1  one-cycle pulse, once per frame.
REQ-011 font_rom_addr  output  11  address to the synchronous font ROM.
REQ-012 font_rom_data  input  8  ROM word, valid one clk after font_rom_addr.
REQ-013 text_on  output  1  overlay pixel lit.
REQ-014 text_src  output  2  index of the source that drew the current text_on pixel.

Function
REQ-015 Stage 0: the block SHALL grant the lowest-index source i with src_on[i]=1 and the suppression condition false, where suppressed = blink_mask[i] AND blink_phase.
  - Grant is fixed priority.
  - Suppressed sources are skipped, and lower-priority sources may then win.
REQ-016 Stage 1 (registered): the block SHALL drive font_rom_addr with the granted src_rom_addr; with no grant it SHALL drive 0.
  - Registered alongside: bit_addr, source index, hit = (grant exists AND video_on).
REQ-017 Stage 2 (registered): the block SHALL set text_on = hit_d1 AND font_rom_data[7 - bit_addr_d1] and text_src = src_d1.
  - text_src SHALL be 0 when hit_d1 = 0.
REQ-018 Latency from src_*/video_on sample to text_on SHALL be exactly 2 clk, with a new pixel accepted every clk and no stalls.
REQ-019 Blink counter SHALL advance only on frame_tick.
  - At value BLINK_FRAMES-1 plus frame_tick it wraps to 0 and toggles blink_phase.
  - Counter width is ceil(log2(BLINK_FRAMES)).
REQ-020 A blink_phase toggle SHALL affect grant decisions from the clk after the toggle; pixels already in stages 1-2 are unaffected.
REQ-021 Simultaneous src_on bits SHALL resolve per REQ-015 only; no fairness or rotation.
REQ-022 video_on=0 SHALL force hit=0 while still updating font_rom_addr per REQ-016.
REQ-023 Source indices >= NUM_SRC SHALL never be granted; text_src is 2 bits, so NUM_SRC SHALL be ≤ 4 (elaboration check).

Reset
REQ-024 While rst_n=0 the block SHALL hold outputs and state at these values:
  - font_rom_addr, text_on, text_src, all pipeline registers, blink counter: 0.
  - blink_phase: 0 (visible).
REQ-025 Reset assertion mid-frame SHALL clear both pipeline stages immediately.
  - The first valid text_on after deassertion follows the first post-reset sample by 2 clk.

Structure
REQ-026 Shared package text_pkg SHALL hold:
  - FONT_ADDR_W=11, FONT_DATA_W=8, GLYPH_COL_W=3.
  - Source index constants SRC_START=0, SRC_SCORE=1, SRC_GAMEOVER=2, SRC_PAUSE=3.
REQ-027 One sub-module, blink_timer (frame_tick counter plus blink_phase toggle), SHALL be instantiated; the arbitration and pipeline stay in the top.

Verification
REQ-028 Single source: src_on=0001, addr0=0x528, bit0=2, ROM word 0x20, video_on=1 -> font_rom_addr=0x528 at +1, text_on=1 with text_src=0 at +2.
REQ-029 Contention: src_on=0110, addr1=0x550, addr2=0x4E0 -> font_rom_addr=0x550 and text_src=1; then drop bit1 -> 0x4E0 and text_src=2.
REQ-030 Blink: BLINK_FRAMES=2, blink_mask=0001, src_on=0001.
  - After 2 frame_ticks, text_on=0 and font_rom_addr=0.
  - After 2 more frame_ticks, text_on returns.
REQ-031 Blink fallthrough: blink_phase=1, blink_mask=0001, src_on=0011 -> source 1 granted, text_src=1.
REQ-032 Blanking: video_on=0 with src_on=0001 and ROM bit set -> text_on=0 while font_rom_addr still tracks addr0.
REQ-033 Reset mid-stream: assert rst_n=0 for 1 clk during continuous hits -> all outputs 0 that cycle; text_on resumes exactly 2 clk after the first post-reset sample.
